// File: rtl/spi_ctrl_pkg.sv
// Shared types and constants for the SPI command sequencer: FSM states,
// opcode encodings, the illegal-command response and the error-counter ceiling.
package spi_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_OPERAND = 2'd1,
        ST_EXEC    = 2'd2
    } state_e;

    typedef enum logic [3:0] {
        OP_WRITE    = 4'h1,
        OP_SET      = 4'h2,
        OP_CLR      = 4'h3,
        OP_TOGGLE   = 4'h4,
        OP_READ_LED = 4'h5,
        OP_READ_ERR = 4'h6
    } opcode_e;

    localparam logic [3:0] RESP_ILLEGAL = 4'hE;
    localparam logic [3:0] ERR_MAX      = 4'hF;

    // Saturating increment used by every error source.
    function automatic logic [3:0] err_inc(input logic [3:0] cnt);
        return (cnt == ERR_MAX) ? cnt : cnt + 4'h1;
    endfunction

endpackage

// File: rtl/spi_timeout_counter.sv
// Opcode-to-operand watchdog: counts cycles while run is high and flags the
// last permitted cycle so the sequencer can give up on a stalled frame.
module spi_timeout_counter #(
    parameter int unsigned TIMEOUT_CYCLES = 50_000_000,
    parameter int unsigned TIMEOUT_W      = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic run,
    output logic expired
);

    logic [TIMEOUT_W-1:0] cnt_q;
    logic [TIMEOUT_W-1:0] cnt_d;

    // Expiry is raised during the TIMEOUT_CYCLES-th waiting cycle, so the
    // sequencer leaves on exactly that cycle's closing edge.
    assign expired = run && (cnt_q == TIMEOUT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (run && !expired) begin
            cnt_d = cnt_q + TIMEOUT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/spi_cmd_controller.sv
// Two-nibble SPI command sequencer driving the LED register, error counter and
// MISO response. Define SPI_CMD_TIMEOUT_EN to abandon frames whose operand stalls.
module spi_cmd_controller
    import spi_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 50_000_000,
    localparam int unsigned TIMEOUT_W     = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] rx_nibble_in,
    input  logic       rx_valid_in,
    input  logic       frame_abort_in,
    output logic [3:0] led_out,
    output logic [3:0] tx_nibble_out,
    output logic       tx_load_out,
    output logic [3:0] err_count_out,
    output logic       busy_out
);

    state_e     state_q, state_d;
    logic [3:0] opcode_q, opcode_d;
    logic [3:0] operand_q, operand_d;
    logic [3:0] led_q, led_d;
    logic [3:0] tx_q, tx_d;
    logic       tx_load_q, tx_load_d;
    logic [3:0] err_q, err_d;
    logic       timeout_expired;

`ifdef SPI_CMD_TIMEOUT_EN
    spi_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TIMEOUT_W      (TIMEOUT_W)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clear   (state_q == ST_IDLE),
        .run     (state_q == ST_OPERAND),
        .expired (timeout_expired)
    );
`else
    // ST_OPERAND waits indefinitely; the timeout parameters stay on the interface.
    assign timeout_expired = 1'b0 & (TIMEOUT_W > 0) & (TIMEOUT_CYCLES > 0);
`endif

    always_comb begin
        state_d   = state_q;
        opcode_d  = opcode_q;
        operand_d = operand_q;
        led_d     = led_q;
        tx_d      = tx_q;
        tx_load_d = 1'b0;
        err_d     = err_q;
        case (state_q)
            ST_IDLE: begin
                if (rx_valid_in && !frame_abort_in) begin
                    opcode_d = rx_nibble_in;
                    state_d  = ST_OPERAND;
                end
            end
            ST_OPERAND: begin
                // Abort beats a coincident operand; an operand beats a coincident timeout.
                if (frame_abort_in) begin
                    opcode_d = '0;
                    err_d    = err_inc(err_q);
                    state_d  = ST_IDLE;
                end else if (rx_valid_in) begin
                    operand_d = rx_nibble_in;
                    state_d   = ST_EXEC;
                end else if (timeout_expired) begin
                    opcode_d = '0;
                    err_d    = err_inc(err_q);
                    state_d  = ST_IDLE;
                end
            end
            ST_EXEC: begin
                state_d   = ST_IDLE;
                tx_load_d = 1'b1;
                case (opcode_q)
                    OP_WRITE:    begin led_d = operand_q;             tx_d = operand_q; end
                    OP_SET:      begin led_d = led_q | operand_q;     tx_d = led_q | operand_q; end
                    OP_CLR:      begin led_d = led_q & ~operand_q;    tx_d = led_q & ~operand_q; end
                    OP_TOGGLE:   begin led_d = led_q ^ operand_q;     tx_d = led_q ^ operand_q; end
                    OP_READ_LED: tx_d = led_q;
                    OP_READ_ERR: begin
                        tx_d = err_q;
                        if (operand_q == 4'h1) begin
                            err_d = '0;
                        end
                    end
                    default: begin
                        tx_d  = RESP_ILLEGAL;
                        err_d = err_inc(err_q);
                    end
                endcase
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            opcode_q  <= '0;
            operand_q <= '0;
            led_q     <= '0;
            tx_q      <= '0;
            tx_load_q <= 1'b0;
            err_q     <= '0;
        end else begin
            state_q   <= state_d;
            opcode_q  <= opcode_d;
            operand_q <= operand_d;
            led_q     <= led_d;
            tx_q      <= tx_d;
            tx_load_q <= tx_load_d;
            err_q     <= err_d;
        end
    end

    assign led_out       = led_q;
    assign tx_nibble_out = tx_q;
    assign tx_load_out   = tx_load_q;
    assign err_count_out = err_q;
    assign busy_out      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_spi_cmd_controller.sv
// Self-checking bench for spi_cmd_controller: directed frames from the test
// plan followed by randomized command, abort and noise traffic.
module tb_spi_cmd_controller;

`ifdef SPI_CMD_TIMEOUT_EN
    localparam int unsigned TB_TIMEOUT = 8;
`else
    localparam int unsigned TB_TIMEOUT = 50_000_000;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] rx_nibble_in = 4'h0;
    logic       rx_valid_in = 1'b0;
    logic       frame_abort_in = 1'b0;
    logic [3:0] led_out;
    logic [3:0] tx_nibble_out;
    logic       tx_load_out;
    logic [3:0] err_count_out;
    logic       busy_out;

    spi_cmd_controller #(.TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
        .clk            (clk),
        .reset          (reset),
        .rx_nibble_in   (rx_nibble_in),
        .rx_valid_in    (rx_valid_in),
        .frame_abort_in (frame_abort_in),
        .led_out        (led_out),
        .tx_nibble_out  (tx_nibble_out),
        .tx_load_out    (tx_load_out),
        .err_count_out  (err_count_out),
        .busy_out       (busy_out)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int         n_checks = 0;
    int         n_fail   = 0;
    int         load_cnt = 0;
    logic [3:0] m_led = 4'h0;
    logic [3:0] m_err = 4'h0;
    logic [3:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Every response pulse must match the oldest outstanding expected response.
    always @(posedge clk) begin
        #2;
        if (tx_load_out === 1'b1) begin
            load_cnt++;
            if (exp_q.size() == 0) begin
                check("unexpected_load", 32'd1, 32'd0);
            end else begin
                check("load_nibble", tx_nibble_out, exp_q.pop_front());
            end
        end
    end

    // Behavioural command semantics.
    task automatic model_exec(input logic [3:0] op, input logic [3:0] opnd, output logic [3:0] resp);
        case (op)
            4'h1: begin m_led = opnd;          resp = m_led; end
            4'h2: begin m_led = m_led | opnd;  resp = m_led; end
            4'h3: begin m_led = m_led & ~opnd; resp = m_led; end
            4'h4: begin m_led = m_led ^ opnd;  resp = m_led; end
            4'h5: resp = m_led;
            4'h6: begin resp = m_err; if (opnd == 4'h1) m_err = 4'h0; end
            default: begin resp = 4'hE; m_err = (m_err == 4'hF) ? 4'hF : m_err + 4'h1; end
        endcase
    endtask

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == 4'hF) ? 4'hF : v + 4'h1;
    endfunction

    // ---------------- drivers (entered and left just after a negedge) ----------------
    task automatic drive(input logic valid, input logic [3:0] n, input logic abort);
        rx_valid_in    = valid;
        rx_nibble_in   = n;
        frame_abort_in = abort;
        @(posedge clk);
        @(negedge clk);
        rx_valid_in    = 1'b0;
        frame_abort_in = 1'b0;
        rx_nibble_in   = 4'($urandom_range(0, 15));
    endtask

    task automatic idle(input int k);
        repeat (k) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_led"}, led_out, m_led);
        check({tag, "_err"}, err_count_out, m_err);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle(1);
        m_led = 4'h0;
        m_err = 4'h0;
        exp_q.delete();
        check("rst_led", led_out, 0);
        check("rst_tx", tx_nibble_out, 0);
        check("rst_load", tx_load_out, 0);
        check("rst_err", err_count_out, 0);
        check("rst_busy", busy_out, 0);
        reset = 1'b0;
    endtask

    task automatic do_cmd(input logic [3:0] op, input logic [3:0] opnd, input int gap, input bit noise);
        int         lc0;
        logic [3:0] resp;
        lc0 = load_cnt;
        drive(1'b1, op, 1'b0);
        check("busy_after_opcode", busy_out, 1);
        check("load_idle", tx_load_out, 0);
        idle(gap);
        model_exec(op, opnd, resp);
        exp_q.push_back(resp);
        drive(1'b1, opnd, 1'b0);
        check("busy_exec", busy_out, 1);
        check("load_early", tx_load_out, 0);
        // Traffic during the execute cycle must be dropped without side effects.
        if (noise) drive(1'b1, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
        else idle(1);
        check("load_pulse", tx_load_out, 1);
        check("tx_nibble", tx_nibble_out, resp);
        check("busy_done", busy_out, 0);
        check("load_count", load_cnt, lc0 + 1);
        check_outputs("cmd");
    endtask

    task automatic do_abort(input logic [3:0] op, input logic [3:0] opnd, input int gap, input bit with_rx);
        int lc0;
        lc0 = load_cnt;
        drive(1'b1, op, 1'b0);
        idle(gap);
        drive(with_rx, opnd, 1'b1);
        m_err = sat_inc(m_err);
        check("abort_busy", busy_out, 0);
        idle(1);
        check("abort_no_load", load_cnt, lc0);
        check_outputs("abort");
    endtask

    task automatic do_idle_drop();
        int lc0;
        lc0 = load_cnt;
        drive(1'b1, 4'($urandom_range(0, 15)), 1'b1);
        check("idle_drop_busy", busy_out, 0);
        drive(1'b0, 4'h0, 1'b1);
        check("idle_abort_busy", busy_out, 0);
        check("idle_drop_load", load_cnt, lc0);
        check_outputs("idle_drop");
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [3:0] op;
        @(negedge clk);
        do_reset();

        do_cmd(4'h1, 4'hA, 0, 1'b0);
        do_cmd(4'h4, 4'hF, 1, 1'b0);
        check("plan_toggle", led_out, 4'h5);
        do_cmd(4'h3, 4'h4, 0, 1'b0);
        check("plan_clr", led_out, 4'h1);
        do_cmd(4'h5, 4'h0, 2, 1'b0);
        check("plan_read_led", tx_nibble_out, 4'h1);

        repeat (17) do_cmd(4'h9, 4'h0, 0, 1'b0);
        check("plan_err_sat", err_count_out, 4'hF);
        do_cmd(4'h6, 4'h1, 0, 1'b0);
        check("plan_read_err", tx_nibble_out, 4'hF);
        check("plan_err_clear", err_count_out, 4'h0);

        do_abort(4'h1, 4'h7, 0, 1'b1);
        check("plan_abort_err", err_count_out, 4'h1);
        do_cmd(4'h1, 4'h7, 0, 1'b0);
        check("plan_after_abort", led_out, 4'h7);
        do_idle_drop();

        // Reset while waiting for the operand.
        drive(1'b1, 4'h1, 1'b0);
        do_reset();
        idle(1);
        check("rst_operand_load", tx_load_out, 0);
        // Reset during the execute cycle.
        do_cmd(4'h1, 4'h9, 0, 1'b0);
        drive(1'b1, 4'h2, 1'b0);
        drive(1'b1, 4'h6, 1'b0);
        do_reset();
        idle(1);
        check("rst_exec_load", tx_load_out, 0);
        check_outputs("rst_exec");

        // Operand on the last permitted waiting cycle always executes.
        do_cmd(4'h1, 4'hC, TB_TIMEOUT > 8 ? 7 : int'(TB_TIMEOUT) - 1, 1'b0);
`ifdef SPI_CMD_TIMEOUT_EN
        begin
            int lc0;
            lc0 = load_cnt;
            drive(1'b1, 4'h1, 1'b0);
            idle(int'(TB_TIMEOUT) - 1);
            check("tmo_still_busy", busy_out, 1);
            idle(1);
            m_err = sat_inc(m_err);
            check("tmo_idle", busy_out, 0);
            check("tmo_no_load", load_cnt, lc0);
            check_outputs("tmo");
            do_abort(4'h2, 4'h3, int'(TB_TIMEOUT) - 1, 1'b0);
        end
`endif

        for (int i = 0; i < 80; i++) begin
            case ($urandom_range(0, 9))
                7: do_abort(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                            $urandom_range(0, 3), 1'($urandom_range(0, 1)));
                8: do_idle_drop();
                9: idle($urandom_range(1, 3));
                default: begin
                    op = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 6));
                    do_cmd(op, 4'($urandom_range(0, 15)), $urandom_range(0, 3), $urandom_range(0, 3) == 0);
                end
            endcase
        end

        idle(2);
        check("exp_q_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
